// File: rtl/fpu_arbiter.sv
// Round-robin arbiter/sequencer sharing one FPU between NUM_REQ requesters.
// Optional WAIT watchdog enabled by defining FPU_ARB_TIMEOUT_EN.
//
// state   | meaning
// S_IDLE    | no command in flight; grant the round-robin winner if FPU not busy
// S_WAIT    | fpu_start held high until fpu_cmd_end (or watchdog expiry)
// S_CAPTURE | latch fpu_result into resp_data
// S_RESP    | resp_valid to the granted requester until its resp_ready
module fpu_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int OP_W           = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*32-1:0]   req_a,
  input  logic [NUM_REQ*32-1:0]   req_b,
  input  logic [NUM_REQ*OP_W-1:0] req_op,
  output logic [NUM_REQ-1:0]      resp_valid,
  input  logic [NUM_REQ-1:0]      resp_ready,
  output logic [31:0]             resp_data,
  output logic                    resp_err,
  output logic                    fpu_start,
  output logic [31:0]             fpu_a,
  output logic [31:0]             fpu_b,
  output logic [OP_W-1:0]         fpu_op,
  input  logic [31:0]             fpu_result,
  input  logic                    fpu_cmd_end,
  input  logic                    fpu_busy,
  output logic                    arb_busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE, S_RESP} e_state;

  e_state               r_state;
  logic [IDX_W-1:0]     r_rr_ptr;
  logic [IDX_W-1:0]     r_grant_id;
  logic [NUM_REQ-1:0]   r_resp_valid;
  logic [31:0]          r_resp_data;
  logic                 r_fpu_start;
  logic [31:0]          r_fpu_a;
  logic [31:0]          r_fpu_b;
  logic [OP_W-1:0]      r_fpu_op;

  logic [IDX_W-1:0]     w_grant_idx;
  logic                 w_grant_found;
  logic                 w_grant;
  logic [NUM_REQ-1:0]   w_grant_oh;
  logic [NUM_REQ-1:0]   w_owner_oh;
  logic [IDX_W-1:0]     w_next_ptr;

  function automatic logic [IDX_W-1:0] f_idx(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  // Walk offsets from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[f_idx(r_rr_ptr, k)]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = f_idx(r_rr_ptr, k);
      end
    end
  end

  assign w_grant    = (r_state == S_IDLE) && !fpu_busy && w_grant_found;
  assign w_grant_oh = w_grant ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_grant_idx) : '0;
  assign w_owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_grant_id;
  assign w_next_ptr = (r_grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_resp_err;
  assign resp_err = r_resp_err;
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_grant_id   <= '0;
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_fpu_start  <= 1'b0;
      r_fpu_a      <= '0;
      r_fpu_b      <= '0;
      r_fpu_op     <= '0;
`ifdef FPU_ARB_TIMEOUT_EN
      r_wait_cnt   <= '0;
      r_resp_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_grant_id  <= w_grant_idx;
            r_fpu_a     <= req_a[w_grant_idx*32 +: 32];
            r_fpu_b     <= req_b[w_grant_idx*32 +: 32];
            r_fpu_op    <= req_op[w_grant_idx*OP_W +: OP_W];
            r_fpu_start <= 1'b1;
`ifdef FPU_ARB_TIMEOUT_EN
            r_wait_cnt  <= CNT_W'(TIMEOUT_CYCLES - 1);
`endif
            r_state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (fpu_cmd_end) begin
            r_fpu_start <= 1'b0;
            r_state     <= S_CAPTURE;
          end
`ifdef FPU_ARB_TIMEOUT_EN
          // Watchdog expiry answers with a quiet NaN and the error flag.
          else if (r_wait_cnt == '0) begin
            r_fpu_start  <= 1'b0;
            r_resp_data  <= 32'h7FC0_0000;
            r_resp_err   <= 1'b1;
            r_resp_valid <= w_owner_oh;
            r_state      <= S_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end
`endif
        end
        S_CAPTURE: begin
          r_resp_data  <= fpu_result;
`ifdef FPU_ARB_TIMEOUT_EN
          r_resp_err   <= 1'b0;
`endif
          r_resp_valid <= w_owner_oh;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready[r_grant_id]) begin
            r_resp_valid <= '0;
            r_rr_ptr     <= w_next_ptr;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = w_grant_oh;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign fpu_start  = r_fpu_start;
  assign fpu_a      = r_fpu_a;
  assign fpu_b      = r_fpu_b;
  assign fpu_op     = r_fpu_op;
  assign arb_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_fpu_arbiter.sv
// Self-checking bench for fpu_arbiter: transaction-level reference model plus
// directed scenarios; the watchdog scenario runs when FPU_ARB_TIMEOUT_EN is defined.
module tb_fpu_arbiter;
  localparam int N    = 4;
  localparam int OP_W = 4;
  localparam int TO   = 16;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
  localparam logic [OP_W-1:0] OP_SQRT = 4'h3;
`ifdef FPU_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready, resp_valid, resp_ready;
  logic [N*32-1:0] req_a = '0;
  logic [N*32-1:0] req_b = '0;
  logic [N*OP_W-1:0] req_op = '0;
  logic [31:0] resp_data, fpu_a, fpu_b;
  logic [31:0] fpu_result = '0;
  logic resp_err, fpu_start, fpu_cmd_end, arb_busy;
  logic fpu_busy = 1'b0;
  logic [OP_W-1:0] fpu_op;

  bit auto_ack = 1'b1;
  logic [N-1:0] manual_ready = '0;
  assign resp_ready = auto_ack ? resp_valid : manual_ready;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fpu_arbiter #(.NUM_REQ(N), .OP_W(OP_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .arst_n(arst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .fpu_start(fpu_start), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op),
    .fpu_result(fpu_result), .fpu_cmd_end(fpu_cmd_end), .fpu_busy(fpu_busy),
    .arb_busy(arb_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- FPU behavioural stand-in ----------------
  int   fpu_lat  = 3;
  bit   fpu_hang = 1'b0;
  bit   fpu_done = 1'b0;
  int   fpu_cnt  = 0;
  logic r_end    = 1'b0;
  logic inj_end  = 1'b0;
  assign fpu_cmd_end = r_end | inj_end;

  function automatic logic [31:0] f_fpu(input logic [31:0] a, input logic [31:0] b, input logic [OP_W-1:0] op);
    if (op == OP_SQRT) return (a == 32'h4180_0000) ? 32'h4080_0000 : 32'h3F80_0000;
    return a + b;
  endfunction

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_end <= 1'b0; fpu_done <= 1'b0; fpu_cnt <= 0;
    end else begin
      r_end <= 1'b0;
      if (fpu_start && !fpu_done) begin
        if (fpu_cnt >= fpu_lat) begin
          r_end      <= !fpu_hang;
          fpu_result <= f_fpu(fpu_a, fpu_b, fpu_op);
          fpu_done   <= 1'b1;
        end else fpu_cnt <= fpu_cnt + 1;
      end else if (!fpu_start) begin
        fpu_done <= 1'b0; fpu_cnt <= 0;
      end
    end
  end

  // ---------------- Reference model (transaction level) ----------------
  int m_ptr = 0, m_owner = -1, m_g = -1, m_wcnt = 0;
  bit m_waiting = 0, m_cap = 0, m_valid = 0;
  logic [31:0] m_data = '0, m_a = '0, m_b = '0;
  logic m_err = 1'b0;
  logic [OP_W-1:0] m_op = '0;

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_ptr = 0; m_owner = -1; m_waiting = 0; m_cap = 0; m_valid = 0; m_wcnt = 0;
      m_data = '0; m_err = 1'b0; m_a = '0; m_b = '0; m_op = '0;
    end else if (m_owner < 0) begin
      m_g = pick(req_valid, m_ptr);
      if (!fpu_busy && m_g >= 0) begin
        m_owner = m_g; m_waiting = 1; m_wcnt = 0;
        m_a = req_a[m_g*32 +: 32]; m_b = req_b[m_g*32 +: 32]; m_op = req_op[m_g*OP_W +: OP_W];
      end
    end else if (m_waiting) begin
      m_wcnt++;
      if (fpu_cmd_end) begin
        m_waiting = 0; m_cap = 1;
      end else if (TO_EN && m_wcnt == TO) begin
        m_waiting = 0; m_valid = 1; m_data = 32'h7FC0_0000; m_err = 1'b1;
      end
    end else if (m_cap) begin
      m_cap = 0; m_valid = 1; m_data = fpu_result; m_err = 1'b0;
    end else if (m_valid && resp_ready[m_owner]) begin
      m_valid = 0; m_ptr = (m_owner + 1) % N; m_owner = -1;
    end
  end

  // ---------------- Per-cycle comparison and bookkeeping ----------------
  int grant_q[$];
  int pulses[N];
  int start_cnt = 0;
  logic [N-1:0] e_ready;

  always @(negedge clk) begin
    m_g = pick(req_valid, m_ptr);
    e_ready = (m_owner < 0 && !fpu_busy && m_g >= 0) ? (N'(1) << m_g) : '0;
    chk("req_ready", 32'(req_ready), 32'(e_ready));
    chk("fpu_start", 32'(fpu_start), 32'(m_owner >= 0 && m_waiting));
    chk("resp_valid", 32'(resp_valid), m_valid ? 32'(1 << m_owner) : 32'd0);
    chk("arb_busy", 32'(arb_busy), 32'(m_owner >= 0));
    chk("resp_data", resp_data, m_data);
    chk("resp_err", 32'(resp_err), 32'(m_err));
    chk("fpu_a", fpu_a, m_a);
    chk("fpu_b", fpu_b, m_b);
    chk("fpu_op", 32'(fpu_op), 32'(m_op));
    for (int i = 0; i < N; i++)
      if (req_ready[i]) begin grant_q.push_back(i); pulses[i]++; end
    if (fpu_start) start_cnt++;
  end

  // ---------------- Directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_cmd(input int id, input logic [31:0] a, input logic [31:0] b, input logic [OP_W-1:0] op);
    req_a[id*32 +: 32] = a; req_b[id*32 +: 32] = b; req_op[id*OP_W +: OP_W] = op;
  endtask

  task automatic wait_resp(input string name, input int id, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (resp_valid[id]) break;
      tick();
    end
    chk(name, 32'(resp_valid[id]), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!arb_busy) break;
      tick();
    end
    chk(name, 32'(arb_busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "tb watchdog");
  end

  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    for (int i = 0; i < N; i++) set_cmd(i, 32'h0000_0100 * (i + 1), 32'h0000_0001 + i, OP_ADD);
    repeat (3) tick();
    chk("reset_fpu_start", 32'(fpu_start), 32'd0);
    chk("reset_busy", 32'(arb_busy), 32'd0);
    chk("reset_resp_data", resp_data, 32'd0);
    arst_n = 1'b1;
    tick();

    // All four requesters from reset, each acked immediately.
    grant_q.delete();
    req_valid = 4'hF;
    for (int i = 0; i < 400; i++) begin
      if (grant_q.size() >= 5) break;
      tick();
    end
    req_valid = '0;
    wait_idle("rr_idle", 100);
    chk("rr_count", 32'(grant_q.size()), 32'd5);
    for (int k = 0; k < 5 && k < grant_q.size(); k++) chk("rr_order", 32'(grant_q[k]), 32'(exp_order[k]));

    // Single sqrt(16.0) from requester 0 with timing check.
    auto_ack = 1'b0; manual_ready = '0;
    for (int i = 0; i < N; i++) pulses[i] = 0;
    set_cmd(0, 32'h4180_0000, 32'h0, OP_SQRT);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    chk("sqrt_fpu_a", fpu_a, 32'h4180_0000);
    chk("sqrt_fpu_op", 32'(fpu_op), 32'(OP_SQRT));
    chk("sqrt_start", 32'(fpu_start), 32'd1);
    for (int i = 0; i < 50; i++) begin
      if (fpu_cmd_end) break;
      tick();
    end
    chk("sqrt_cmd_end", 32'(fpu_cmd_end), 32'd1);
    tick();
    chk("sqrt_c1_start", 32'(fpu_start), 32'd0);
    chk("sqrt_c1_valid", 32'(resp_valid), 32'd0);
    tick();
    chk("sqrt_c2_valid", 32'(resp_valid), 32'b0001);
    chk("sqrt_c2_data", resp_data, 32'h4080_0000);
    manual_ready = 4'b0001;
    tick();
    manual_ready = '0;
    chk("sqrt_pulses", 32'(pulses[0]), 32'd1);
    chk("sqrt_hold_data", resp_data, 32'h4080_0000);

    // Requester 2 stalls its response while requester 1 waits.
    set_cmd(2, 32'h0000_2000, 32'h0000_0022, OP_ADD);
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0010;
    wait_resp("stall_resp2", 2, 50);
    chk("stall_data", resp_data, 32'h0000_2022);
    manual_ready = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      inj_end = (i == 5);
      chk("stall_start", 32'(fpu_start), 32'd0);
      chk("stall_ready1", 32'(req_ready[1]), 32'd0);
      tick();
    end
    inj_end = 1'b0;
    chk("stall_still_valid", 32'(resp_valid), 32'b0100);
    manual_ready = 4'b0100;
    tick();
    manual_ready = '0;
    chk("after_ack_grant1", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    auto_ack = 1'b1;
    wait_idle("stall_idle", 100);

    // FPU busy blocks the grant; release grants in the same cycle.
    fpu_busy = 1'b1;
    req_valid = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("busy_no_grant", 32'(req_ready), 32'd0);
    end
    fpu_busy = 1'b0;
    #1;
    chk("busy_release_grant", 32'(req_ready), 32'b1000);
    tick();
    req_valid = '0;
    wait_idle("busy_idle", 100);

    // Move rr_ptr away from 0, then reset in the middle of WAIT.
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    wait_idle("pre_rst_idle", 100);
    fpu_lat = 20;
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick(); tick();
    chk("rst_pre_start", 32'(fpu_start), 32'd1);
    #2 arst_n = 1'b0;
    #1;
    chk("rst_start", 32'(fpu_start), 32'd0);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_busy", 32'(arb_busy), 32'd0);
    tick(); tick();
    arst_n = 1'b1;
    fpu_lat = 3;
    tick();
    req_valid = 4'b1001;
    #1;
    chk("rst_ptr_grant0", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    wait_idle("rst_idle", 100);

`ifdef FPU_ARB_TIMEOUT_EN
    // FPU never finishes: watchdog response, then a normal one.
    fpu_hang = 1'b1;
    start_cnt = 0;
    auto_ack = 1'b0;
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    wait_resp("to_resp", 1, 100);
    chk("to_start_cycles", 32'(start_cnt), 32'd16);
    chk("to_data", resp_data, 32'h7FC0_0000);
    chk("to_err", 32'(resp_err), 32'd1);
    manual_ready = 4'b0010;
    tick();
    manual_ready = '0;
    auto_ack = 1'b1;
    fpu_hang = 1'b0;
    set_cmd(2, 32'h0000_0010, 32'h0000_0020, OP_ADD);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    wait_resp("to_next_resp", 2, 100);
    chk("to_next_data", resp_data, 32'h0000_0030);
    chk("to_next_err", 32'(resp_err), 32'd0);
    wait_idle("to_idle", 100);
`endif

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fpu_arbiter.md
# fpu_arbiter

- Round-robin arbiter and sequencer that shares one `fpu` instance between `NUM_REQ` requesters.
- It accepts operand/operation commands over per-requester valid/ready handshakes, drives the FPU's level-held `start` protocol until `cmd_end`, and returns the captured result to the granting requester.
- It sits between the CPU-side/microcode requesters and the single FPU datapath.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2–8).
- `OP_W`, 4: width of one packed `pa_fpu::e_fpu_op` field.
- `TIMEOUT_CYCLES`, 1024: watchdog limit; used only with `FPU_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock.
- `arst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  command request, one bit per requester.
- `req_ready`  out  NUM_REQ  one-hot grant/accept pulse.
- `req_a`  in  NUM_REQ*32  packed operand A (requester i at [32i+31:32i]).
- `req_b`  in  NUM_REQ*32  packed operand B.
- `req_op`  in  NUM_REQ*OP_W  packed operation codes.
- `resp_valid`  out  NUM_REQ  one-hot result valid.
- `resp_ready`  in  NUM_REQ  result accept.
- `resp_data`  out  32  result, IEEE-754 single.
- `resp_err`  out  1  timeout flag, qualified by `resp_valid`.
- `fpu_start`  out  1  to `fpu.start`.
- `fpu_a`, `fpu_b`  out  32  to `fpu.a_operand` / `fpu.b_operand`.
- `fpu_op`  out  OP_W  to `fpu.operation`.
- `fpu_result`  in  32  from `fpu.ieee_packet_out`.
- `fpu_cmd_end`  in  1  from `fpu.cmd_end`.
- `fpu_busy`  in  1  from `fpu.busy`.
- `arb_busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, WAIT, CAPTURE, RESP.
- **IDLE**
  - Grants when any `req_valid` is high and `fpu_busy`=0.
  - Grant goes to the first set bit at or after `rr_ptr`, searching with wrap-around.
  - `req_ready[g]` is combinational and high only in this cycle.
  - `fpu_a`/`fpu_b`/`fpu_op`/`grant_id` are registered from requester g.
  - Next state is WAIT.
  - If `fpu_busy`=1, nothing is granted.
- **WAIT**
  - `fpu_start`=1 throughout.
  - Operand and op registers hold steady.
  - When `fpu_cmd_end`=1, `fpu_start` drops on the next cycle and the state goes to CAPTURE.
- **CAPTURE**: `resp_data` is loaded from `fpu_result`, `resp_err` is set to 0, and the state goes to RESP.
- **RESP**
  - `resp_valid[grant_id]`=1 until `resp_ready[grant_id]`=1.
  - `resp_ready` bits of other requesters are ignored.
  - On accept: `rr_ptr` = (`grant_id`+1) mod `NUM_REQ`, `resp_valid` clears, and the state returns to IDLE.
- Requesters hold `req_valid` and the command stable until `req_ready`; dropping `req_valid` earlier is permitted and withdraws the request without side effects.
- New requests arriving during WAIT/CAPTURE/RESP wait; there is no queuing beyond the requester's held valid.
- `resp_data` holds its value after accept until the next CAPTURE.

## Timing
- Reset values:
  - State IDLE and `rr_ptr`=0.
  - `req_ready`=0, `resp_valid`=0, `resp_data`=0, `resp_err`=0.
  - `fpu_start`=0, `fpu_a`=0, `fpu_b`=0, `fpu_op`=0.
  - `arb_busy`=0.
- Reset mid-operation:
  - Everything returns immediately (asynchronously) to the reset values, and `fpu_start` drops.
  - An in-flight result is discarded and no response is issued.
- Grant in cycle T; `fpu_start` high from T+1.
- `fpu_cmd_end` sampled high in cycle C:
  - `fpu_start` low from C+1.
  - `resp_data` is valid and `resp_valid` is high from C+2.
- Minimum turnaround: `resp_ready` at cycle R allows the next grant in R+1.
- `fpu_cmd_end` outside WAIT is ignored.
- `fpu_busy` is only checked in IDLE.
- When requests are simultaneous, one grant is made per cycle, and its choice is fixed by `rr_ptr` at that cycle.

## Configuration
- **`FPU_ARB_TIMEOUT_EN` defined**
  - A WAIT cycle counter is cleared on entry to WAIT.
  - If it reaches `TIMEOUT_CYCLES` without `fpu_cmd_end`, the block drops `fpu_start` and goes to RESP.
  - In that case `resp_data`=32'h7FC00000 and `resp_err`=1.
- **Undefined**
  - The block waits indefinitely in WAIT.
  - No counter is synthesized.
  - `resp_err` is tied to 0.

## Test plan
- Single request: requester 0 issues sqrt with A=32'h41800000 (16.0) → `req_ready[0]` pulses once, `fpu_start` is held until `cmd_end`, and `resp_valid[0]` returns `resp_data`=32'h40800000 at C+2.
- All four `req_valid` high from reset, each `resp_ready` acked on the first valid cycle → grants in order 0,1,2,3,0, with each response routed only to its own requester.
- Requester 2 holds `resp_ready`=0 for 20 cycles while requester 1 is valid → no new `fpu_start` and `req_ready[1]`=0 until the ack; then requester 1 is granted on the next cycle.
- `fpu_busy`=1 with `req_valid[3]`=1 → no grant; `fpu_busy` falls → `req_ready[3]` pulses that cycle.
- `arst_n` asserted in WAIT with `fpu_start`=1 → `fpu_start`, `resp_valid` and `arb_busy` are 0 immediately; after release, the next request is granted from `rr_ptr`=0.
- With `FPU_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, the FPU model never raises `cmd_end` → after 16 WAIT cycles `resp_valid`=1, `resp_data`=32'h7FC00000, `resp_err`=1; the next request completes normally with `resp_err`=0.
